// File: rtl/aes256_key_sched_if.sv
// Key-schedule control and round-key read bus.
// The round datapath or bench drives the master side; the key scheduler is the slave.
interface aes256_key_sched_if;
  logic         start;
  logic [255:0] key;
  logic         busy;
  logic         done;
  logic         key_valid;
  logic [14:0]  rounds_ready;
  logic         rd_en;
  logic [3:0]   rd_round;
  logic         rd_valid;
  logic [127:0] rd_key;

  modport master (
    output start, key, rd_en, rd_round,
    input  busy, done, key_valid, rounds_ready, rd_valid, rd_key
  );

  modport slave (
    input  start, key, rd_en, rd_round,
    output busy, done, key_valid, rounds_ready, rd_valid, rd_key
  );
endinterface

// File: rtl/aes256_key_sched.sv
// Sequential AES-256 key expansion: one word per clock through a single S-box word.
// All 15 round keys are kept in a word file and served through a registered read port.
module sub_word (
  input  logic [31:0] din,
  output logic [31:0] dout
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b lives at bits [8*(255-b)+7 -: 8], i.e. index {~b, 3'b111}.
  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  assign dout = {sb(din[31:24]), sb(din[23:16]), sb(din[15:8]), sb(din[7:0])};
endmodule

module aes256_key_sched #(
  parameter int unsigned NR = 14,
  parameter int unsigned NK = 8
) (
  input logic clk,
  input logic rst,
  aes256_key_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  localparam logic [5:0] LASTW = 6'(4 * (NR + 1) - 1);

  state_t       state, state_nxt;
  logic         load, last;
  logic [5:0]   i;
  // 64 entries so every 6-bit word index, including out-of-range round reads, stays in bounds.
  logic [31:0]  w [64];
  logic [31:0]  prev, old, sub_in, sub_out, nword;
  logic [7:0]   rcon;
  logic         done_q;
  logic [14:0]  rr;
  logic [15:0]  rr_ext;
  logic         rd_valid_q;
  logic [127:0] rd_key_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE, READY: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        if (i == LASTW) begin
          last      = 1'b1;
          state_nxt = READY;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    prev   = w[i - 6'd1];
    old    = w[i - 6'd8];
    sub_in = (i[2:0] == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    rcon   = 8'h01 << (i[5:3] - 3'd1);
    case (i[2:0])
      3'd0:    nword = old ^ sub_out ^ {rcon, 24'h0};
      3'd4:    nword = old ^ sub_out;
      default: nword = old ^ prev;
    endcase
  end

  sub_word u_sub_word (
    .din  (sub_in),
    .dout (sub_out)
  );

  assign rr_ext = {1'b0, rr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i          <= '0;
      done_q     <= 1'b0;
      rr         <= '0;
      rd_valid_q <= 1'b0;
      rd_key_q   <= '0;
      for (int unsigned k = 0; k < 64; k++) w[k[5:0]] <= '0;
    end else begin
      done_q <= last;
      if (load) begin
        for (int unsigned k = 0; k < NK; k++) w[k[5:0]] <= bus.key[255 - 32*k -: 32];
        i  <= 6'd8;
        rr <= 15'b11;
      end else if (state == EXPAND) begin
        w[i] <= nword;
        if (i != LASTW) i <= i + 6'd1;
        if (i[1:0] == 2'b11) rr <= rr | (15'b1 << i[5:2]);
      end
      // Reads see pre-edge storage and ready bits, so a round is served only once it is visible.
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        if (rr_ext[bus.rd_round])
          rd_key_q <= {w[{bus.rd_round, 2'd0}], w[{bus.rd_round, 2'd1}],
                       w[{bus.rd_round, 2'd2}], w[{bus.rd_round, 2'd3}]};
        else
          rd_key_q <= '0;
      end
    end
  end

  assign bus.busy         = (state == EXPAND);
  assign bus.key_valid    = (state == READY);
  assign bus.done         = done_q;
  assign bus.rounds_ready = rr;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_key       = rd_key_q;
endmodule

// File: tb/tb_aes256_key_sched.sv
// Bench for aes256_key_sched: cycle-counting reference model with a GF(2^8)-derived S-box,
// checked every cycle, plus directed FIPS-197 A.3 vectors.
module tb_aes256_key_sched;
  typedef logic [31:0] words_t [60];

  localparam logic [255:0] KA = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KB = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KA_R2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] KA_R14 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes256_key_sched_if bus ();

  aes256_key_sched #(.NR(14), .NK(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int busy_cnt = 0;
  int ts       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse (a^254) then the affine map.
  function automatic logic [7:0] sbox_b(input logic [7:0] b);
    logic [7:0] v = 8'h01;
    for (int k = 0; k < 254; k++) v = gmul(v, b);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_b(x[31:24]), sbox_b(x[23:16]), sbox_b(x[15:8]), sbox_b(x[7:0])};
  endfunction

  task automatic compute(input logic [255:0] k, output words_t w);
    logic [7:0]  rc;
    logic [31:0] t;
    rc = 8'h01;
    for (int n = 0; n < 8; n++) w[n] = k[255 - 32*n -: 32];
    for (int n = 8; n < 60; n++) begin
      t = w[n-1];
      if (n % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (n % 8 == 4) begin
        t = subw(t);
      end
      w[n] = w[n-8] ^ t;
    end
  endtask

  function automatic logic [127:0] rk(input words_t w, input int r);
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Reference model: counts cycles since the accepted start; whole schedule computed up front.
  words_t       m_w;
  logic         m_busy, m_done, m_kv, m_rdv;
  logic [14:0]  m_rr;
  logic [15:0]  m_rr_ext;
  logic [127:0] m_rdk;
  int           m_n;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_kv = 1'b0; m_rdv = 1'b0;
      m_rr = '0; m_rdk = '0; m_n = 0;
    end else begin
      m_rr_ext = {1'b0, m_rr};
      if (bus.rd_en) begin
        m_rdv = 1'b1;
        m_rdk = m_rr_ext[bus.rd_round] ? rk(m_w, int'(bus.rd_round)) : '0;
      end else begin
        m_rdv = 1'b0;
      end
      m_done = 1'b0;
      if (m_busy) begin
        m_n++;
        if (m_n % 4 == 0) m_rr[m_n/4 + 1] = 1'b1;
        if (m_n == 52) begin
          m_busy = 1'b0; m_kv = 1'b1; m_done = 1'b1;
        end
      end else if (bus.start) begin
        compute(bus.key, m_w);
        m_busy = 1'b1; m_kv = 1'b0; m_rr = 15'h3; m_n = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("busy",         128'(bus.busy),         128'(m_busy));
      chk("done",         128'(bus.done),         128'(m_done));
      chk("key_valid",    128'(bus.key_valid),    128'(m_kv));
      chk("rounds_ready", 128'(bus.rounds_ready), 128'(m_rr));
      chk("rd_valid",     128'(bus.rd_valid),     128'(m_rdv));
      chk("rd_key",       bus.rd_key,             m_rdk);
      if (bus.busy) busy_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rd(input logic [3:0] r, output logic v, output logic [127:0] d);
    bus.rd_en    = 1'b1;
    bus.rd_round = r;
    step();
    v = bus.rd_valid;
    d = bus.rd_key;
    bus.rd_en = 1'b0;
  endtask

  task automatic do_start(input logic [255:0] k);
    bus.start = 1'b1;
    bus.key   = k;
    busy_cnt  = 0;
    step();
    ts        = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 80 && bus.done !== 1'b1; k++) step();
    chk({tag, "_done_seen"}, 128'(bus.done), 128'(1'b1));
    chk({tag, "_latency"},   128'(cyc - ts), 128'(52));
    chk({tag, "_busy_cycles"}, 128'(busy_cnt), 128'(52));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got t=%0t expected finish earlier", $time);
    $fatal(1);
  end

  initial begin
    words_t       ref_w;
    logic         v;
    logic [127:0] d;

    bus.start = 1'b0; bus.key = '0; bus.rd_en = 1'b0; bus.rd_round = '0;

    compute(KA, ref_w);
    chk("model_w8",  128'(ref_w[8]), 128'(32'h9ba35411));
    chk("model_r2",  rk(ref_w, 2),   KA_R2);
    chk("model_r14", rk(ref_w, 14),  KA_R14);

    step(); step();
    rst = 1'b0;
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_kv",   128'(bus.key_valid), 128'(0));
    chk("rst_rr",   128'(bus.rounds_ready), 128'(0));
    chk("rst_rdkey", bus.rd_key, '0);
    rd(4'd0, v, d);
    chk("idle_rd_valid", 128'(v), 128'(1));
    chk("idle_rd_key",   d, '0);

    do_start(KA);
    chk("start_rr",   128'(bus.rounds_ready), 128'(15'h0003));
    chk("start_busy", 128'(bus.busy), 128'(1));
    step(); step(); step();
    chk("rr2_T3", 128'(bus.rounds_ready[2]), 128'(0));
    step();
    chk("rr2_T4", 128'(bus.rounds_ready[2]), 128'(1));
    repeat (5) step();
    rd(4'd14, v, d);
    chk("early_r14_valid", 128'(v), 128'(1));
    chk("early_r14_key",   d, '0);
    repeat (9) step();
    bus.start = 1'b1; bus.key = KB;
    step();
    bus.start = 1'b0;
    wait_done("a3");
    chk("ready_kv", 128'(bus.key_valid), 128'(1));
    chk("ready_rr", 128'(bus.rounds_ready), 128'(15'h7fff));
    step();
    chk("done_one_cycle", 128'(bus.done), 128'(0));
    rd(4'd14, v, d);
    chk("a3_r14", d, KA_R14);
    rd(4'd2, v, d);
    chk("a3_r2", d, KA_R2);
    rd(4'd15, v, d);
    chk("oob_valid", 128'(v), 128'(1));
    chk("oob_key",   d, '0);

    do_start(KA);
    chk("restart_kv", 128'(bus.key_valid), 128'(0));
    chk("restart_rr", 128'(bus.rounds_ready), 128'(15'h0003));
    repeat (29) step();
    rst = 1'b1;
    step(); step();
    chk("midrst_kv", 128'(bus.key_valid), 128'(0));
    chk("midrst_rr", 128'(bus.rounds_ready), 128'(0));
    rst = 1'b0;
    repeat (30) step();
    chk("midrst_idle_busy", 128'(bus.busy), 128'(0));
    chk("midrst_idle_kv",   128'(bus.key_valid), 128'(0));

    do_start(KA);
    wait_done("again");
    rd(4'd14, v, d);
    chk("again_r14", d, KA_R14);
    rd(4'd2, v, d);
    chk("again_r2", d, KA_R2);
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aes256_key_sched.md
Name: aes256_key_sched

Overview:
- Sequential AES-256 key schedule controller.
- Loads a 256-bit cipher key on a start handshake and generates expanded words w[8]..w[59] at one word per clock, reusing a single 32-bit S-box lookup.
- Stores all 15 round keys in a register file and serves them to the round datapath through a registered read port.
- Publishes per-round availability so encryption can begin before expansion finishes.

Parameters:
- NR, 14, number of AES rounds; round keys 0..NR are stored. Fixed at 14 for AES-256; other values are unsupported.
- NK, 8, number of key words; fixed at 8.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to load key and begin expansion.
- key  input  256  cipher key; word 0 in bits [255:224].
- busy  output  1  expansion in progress.
- done  output  1  one-cycle pulse when w[59] is stored.
- key_valid  output  1  all 15 round keys valid.
- rounds_ready  output  15  bit r set when round key r is stored.
- rd_en  input  1  round-key read request.
- rd_round  input  4  round index, 0..14.
- rd_valid  output  1  read data valid, one cycle after rd_en.
- rd_key  output  128  round key r = w[4r]..w[4r+3], with w[4r] in bits [127:96].

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state=IDLE, i=0;
  - busy, done, key_valid, rd_valid = 0;
  - rounds_ready = 0, rd_key = 0;
  - word storage = 0.
- Reset applies at any time, including mid-expansion; no partial keys survive it.
- State machine, IDLE -> EXPAND -> READY:
  - In IDLE or READY, start=1 at edge T: latch key into w[0..7], set i=8, busy=1, key_valid=0, rounds_ready=15'b11, go to EXPAND.
  - In EXPAND: start is ignored.
- EXPAND computes w[i] in one cycle and increments i:
  - i%8==0: w[i] = w[i-8] ^ SubWord(RotWord(w[i-1])) ^ {rcon(i/8), 24'h0}.
  - i%8==4: w[i] = w[i-8] ^ SubWord(w[i-1]).
  - Otherwise: w[i] = w[i-8] ^ w[i-1].
  - RotWord is a left byte rotate: {b1,b2,b3,b0}.
  - rcon(1..7) = 01, 02, 04, 08, 10, 20, 40 (hex).
  - Only one SubWord instance (the team's sub_word, 32-bit in/out, combinational) exists. Its input is muxed between RotWord(w[i-1]) and w[i-1].
- rounds_ready[r] sets at the edge that writes w[4r+3].
- Timing: w[8] is written at edge T+1 and w[59] at edge T+52.
  - At T+52: go to READY, busy=0, key_valid=1, done=1 for exactly one cycle.
  - Total latency from start to done is 52 cycles.
- start=1 in READY restarts expansion. key_valid and rounds_ready[14:2] clear at that edge. Old round keys 0,1 are overwritten by the new key.
- Read port:
  - rd_en=1 at edge E gives rd_valid=1 for the cycle after E, with rd_key = round key rd_round.
  - rd_round>14 or rounds_ready[rd_round]=0 returns rd_key=0. rd_valid still asserts.
  - rd_en=0 gives rd_valid=0; rd_key holds its last value.
  - A read and an expansion write in the same cycle are both legal. The read returns pre-edge storage; a round becomes readable only once its rounds_ready bit is visible.
- Width rules: i is 6 bits and saturates at 59; no wrap occurs.

Test Plan:
- Reset then idle:
  - Stimulus: assert rst for 2 cycles, release.
  - Required: all outputs 0; rd_en with rd_round=0 returns rd_valid=1, rd_key=0.
- FIPS-197 A.3 key, start one cycle:
  - Stimulus: key=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4.
  - Required: done pulses exactly 52 cycles later; busy high for 52 cycles.
  - Required: round 2 reads 9ba354118e6925afa51a8b5f2067fcde.
  - Required: round 14 reads fe4890d1e6188d0b046df344706c631e.
- Early availability:
  - rounds_ready = 0x0003 right after start.
  - rounds_ready[2] sets at T+4.
  - Reading round 14 at T+10 returns 0; reading it after done returns the correct value.
- start while busy:
  - Stimulus: pulse start with a different key at T+20.
  - Required: ignored; done still at T+52 with the round 14 value from the first key.
- Reset mid-expansion:
  - Stimulus: rst at T+30.
  - Required: key_valid=0, rounds_ready=0, no done pulse.
  - Then restart with the same key: correct results, done 52 cycles after the new start.
- Out-of-range read:
  - Stimulus: rd_round=15 after done.
  - Required: rd_valid=1, rd_key=0.
